// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the fetch/control logic and the pipeline register sequencer.
interface pipeline_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int WIDTH      = 96
);
  logic                        in_valid;
  logic [NUM_STAGES*WIDTH-1:0] next_data;
  logic                        freeze;
  logic                        hold;
  logic [2:0]                  hold_depth;
  logic                        flush;
  logic [NUM_STAGES*WIDTH-1:0] cur_data;
  logic [NUM_STAGES-1:0]       cur_valid;
  logic [NUM_STAGES-1:0]       advance;
  logic                        retire_valid;
  logic [31:0]                 retire_count;
  logic [31:0]                 stall_count;

  // Control side: drives stage inputs and pipeline control, observes register state.
  modport master (
    output in_valid, next_data, freeze, hold, hold_depth, flush,
    input  cur_data, cur_valid, advance, retire_valid, retire_count, stall_count
  );

  // Sequencer side: owns the inter-stage registers and counters.
  modport slave (
    input  in_valid, next_data, freeze, hold, hold_depth, flush,
    output cur_data, cur_valid, advance, retire_valid, retire_count, stall_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Inter-stage register sequencer: resolves freeze/flush/hold per register each cycle,
// keeps per-register valid bits and counts retired instructions and stall cycles.
module pipeline_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int WIDTH       = 96,
  parameter int FLUSH_STAGE = 2
) (
  input logic                clk,
  input logic                rst,
  pipeline_sequencer_if.slave bus
);

  // Per-register action for the coming edge.
  localparam logic [1:0] ACT_ADVANCE = 2'd0;
  localparam logic [1:0] ACT_KEEP    = 2'd1;
  localparam logic [1:0] ACT_BUBBLE  = 2'd2;

  logic [NUM_STAGES*WIDTH-1:0] r_data;
  logic [NUM_STAGES-1:0]       r_valid;
  logic                        r_retireValid;
  logic [31:0]                 r_retireCount;
  logic [31:0]                 r_stallCount;

  logic [3:0]            w_holdIdx;
  logic                  w_holdHonoured;
  logic [1:0]            w_action [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_validSrc;
  logic [NUM_STAGES-1:0] w_advance;
  logic                  w_retireNext;

  // Out-of-range bubble depths collapse onto the last register.
  always_comb begin
    w_holdIdx = 4'(NUM_STAGES - 1);
    if (bus.hold_depth >= 3'd1 && {1'b0, bus.hold_depth} <= 4'(NUM_STAGES - 1))
      w_holdIdx = {1'b0, bus.hold_depth};
  end

  // A hold is dropped under freeze, or when a same-cycle flush already covers its bubble slot.
  assign w_holdHonoured = bus.hold && !bus.freeze &&
                          !(bus.flush && (w_holdIdx < 4'(FLUSH_STAGE)));

  // Valid bit each register would take on a normal advance.
  assign w_validSrc = {r_valid[NUM_STAGES-2:0], bus.in_valid};

  // Resolve freeze > flush > hold > advance independently for every register.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_action[i] = ACT_ADVANCE;
      if (bus.freeze) begin
        w_action[i] = ACT_KEEP;
      end else if (bus.flush && (i < FLUSH_STAGE)) begin
        w_action[i] = ACT_BUBBLE;
      end else if (w_holdHonoured) begin
        if (4'(i) < w_holdIdx)
          w_action[i] = ACT_KEEP;
        else if (4'(i) == w_holdIdx)
          w_action[i] = ACT_BUBBLE;
      end
    end
  end

  // Load enables: a register advances only when it takes its stage's next value.
  always_comb begin
    w_advance = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      w_advance[i] = !rst && (w_action[i] == ACT_ADVANCE);
  end

  assign w_retireNext = (w_action[NUM_STAGES-1] == ACT_ADVANCE) && w_validSrc[NUM_STAGES-1];

  // Register update, retire pulse and counters; reset overrides every control input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data        <= '0;
      r_valid       <= '0;
      r_retireValid <= 1'b0;
      r_retireCount <= 32'd0;
      r_stallCount  <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        case (w_action[i])
          ACT_ADVANCE: begin
            r_data[i*WIDTH +: WIDTH] <= bus.next_data[i*WIDTH +: WIDTH];
            r_valid[i]               <= w_validSrc[i];
          end
          ACT_BUBBLE: begin
            r_data[i*WIDTH +: WIDTH] <= '0;
            r_valid[i]               <= 1'b0;
          end
          default: begin
          end
        endcase
      end
      r_retireValid <= w_retireNext;
      if (w_retireNext)
        r_retireCount <= r_retireCount + 32'd1;
      if (bus.freeze || w_holdHonoured)
        r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign bus.cur_data     = r_data;
  assign bus.cur_valid    = r_valid;
  assign bus.advance      = w_advance;
  assign bus.retire_valid = r_retireValid;
  assign bus.retire_count = r_retireCount;
  assign bus.stall_count  = r_stallCount;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer (4 stages, 96-bit payload, flush of R0..R1).
module tb_pipeline_sequencer;

  localparam int N = 4;
  localparam int W = 96;
  localparam logic [N*W-1:0] P1 = {96'h3D, 96'h2C, 96'h1B, 96'h0A};
  localparam logic [N*W-1:0] PQ = {96'h43, 96'h42, 96'h41, 96'h40};
  localparam logic [N*W-1:0] PF = {96'h55, 96'h54, 96'h53, 96'h52};

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipeline_sequencer_if #(.NUM_STAGES(N), .WIDTH(W)) bus ();

  pipeline_sequencer #(.NUM_STAGES(N), .WIDTH(W), .FLUSH_STAGE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [N*W-1:0] observed,
                             input logic [N*W-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  task automatic setInputs(input logic r, input logic v, input logic [N*W-1:0] d,
                           input logic fr, input logic h, input logic [2:0] hd,
                           input logic fl);
    rst            = r;
    bus.in_valid   = v;
    bus.next_data  = d;
    bus.freeze     = fr;
    bus.hold       = h;
    bus.hold_depth = hd;
    bus.flush      = fl;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [N*W-1:0] d,
                               input logic fr, input logic h, input logic [2:0] hd,
                               input logic fl);
    setInputs(r, v, d, fr, h, hd, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [N*W-1:0] data,
                            input logic [N-1:0] valid, input logic rv);
    checkOutput({tag, "_data"}, bus.cur_data, data);
    checkOutput({tag, "_valid"}, N*W'(bus.cur_valid), N*W'(valid));
    checkOutput({tag, "_retire"}, N*W'(bus.retire_valid), N*W'(rv));
  endtask

  initial begin
    logic [N-1:0] expValid;
    total = 0;
    bad   = 0;
    setInputs(1'b1, 1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Reset state.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("reset", '0, 4'b0000, 1'b0);
    checkOutput("reset_rcount", N*W'(bus.retire_count), '0);
    checkOutput("reset_scount", N*W'(bus.stall_count), '0);

    // Fill: valid front walks in, retire begins on the fourth edge.
    setInputs(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("fill_advance", N*W'(bus.advance), N*W'(4'b1111));
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
      expValid = (k >= 4) ? 4'b1111 : 4'((1 << k) - 1);
      checkOutput($sformatf("fill%0d_valid", k), N*W'(bus.cur_valid), N*W'(expValid));
      checkOutput($sformatf("fill%0d_retire", k), N*W'(bus.retire_valid), N*W'(k >= 4));
    end
    checkOutput("fill_data", bus.cur_data, P1);
    checkOutput("fill_rcount", N*W'(bus.retire_count), N*W'(5));

    // Freeze for three cycles with a full pipe: nothing moves.
    setInputs(1'b0, 1'b1, PF, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    checkOutput("freeze_advance", N*W'(bus.advance), '0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b1, PF, 1'b1, 1'b0, 3'd0, 1'b0);
      checkState($sformatf("freeze%0d", k), P1, 4'b1111, 1'b0);
    end
    checkOutput("freeze_scount", N*W'(bus.stall_count), N*W'(3));
    checkOutput("freeze_rcount", N*W'(bus.retire_count), N*W'(5));

    // Hold at depth 2: R0,R1 keep, R2 bubbles, R3 advances.
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    setInputs(1'b0, 1'b1, PQ, 1'b0, 1'b1, 3'd2, 1'b0);
    #1;
    checkOutput("hold2_advance", N*W'({bus.advance[3], bus.advance[1:0]}), N*W'(3'b100));
    applyStimulus(1'b0, 1'b1, PQ, 1'b0, 1'b1, 3'd2, 1'b0);
    checkState("hold2", {96'h43, 96'h0, 96'h1B, 96'h0A}, 4'b1011, 1'b1);
    checkOutput("hold2_scount", N*W'(bus.stall_count), N*W'(4));
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("hold2_a", P1, 4'b0111, 1'b0);
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("hold2_b", P1, 4'b1111, 1'b1);
    checkOutput("hold2_rcount", N*W'(bus.retire_count), N*W'(8));

    // Flush: R0,R1 squashed, then a two-cycle retire gap.
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b1);
    checkState("flush", {96'h3D, 96'h2C, 96'h0, 96'h0}, 4'b1100, 1'b1);
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("flush_a", P1, 4'b1001, 1'b1);
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("flush_b", P1, 4'b0011, 1'b0);
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("flush_c", P1, 4'b0111, 1'b0);
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("flush_d", P1, 4'b1111, 1'b1);
    checkOutput("flush_rcount", N*W'(bus.retire_count), N*W'(11));
    checkOutput("flush_scount", N*W'(bus.stall_count), N*W'(4));

    // Flush with hold at depth 1: hold ignored, no stall counted.
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b1, 3'd1, 1'b1);
    checkState("flhold1", {96'h3D, 96'h2C, 96'h0, 96'h0}, 4'b1100, 1'b1);
    checkOutput("flhold1_scount", N*W'(bus.stall_count), N*W'(4));
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("flhold1_refill", N*W'(bus.cur_valid), N*W'(4'b1111));
    checkOutput("flhold1_rcount", N*W'(bus.retire_count), N*W'(14));

    // Flush with hold at depth 3: R0,R1 flushed, R2 held, R3 bubbles, stall counted.
    applyStimulus(1'b0, 1'b1, PQ, 1'b0, 1'b1, 3'd3, 1'b1);
    checkState("flhold3", {96'h0, 96'h2C, 96'h0, 96'h0}, 4'b0100, 1'b0);
    checkOutput("flhold3_scount", N*W'(bus.stall_count), N*W'(5));
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("flhold3_refill", N*W'(bus.cur_valid), N*W'(4'b1111));
    checkOutput("flhold3_rcount", N*W'(bus.retire_count), N*W'(16));

    // Hold depth 0 is out of range and acts as depth 3.
    applyStimulus(1'b0, 1'b1, PQ, 1'b0, 1'b1, 3'd0, 1'b0);
    checkState("hold0", {96'h0, 96'h2C, 96'h1B, 96'h0A}, 4'b0111, 1'b0);
    checkOutput("hold0_scount", N*W'(bus.stall_count), N*W'(6));
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("hold0_a", P1, 4'b1111, 1'b1);
    checkOutput("hold0_rcount", N*W'(bus.retire_count), N*W'(17));

    // Retire counter wraps from all-ones to zero.
    force dut.r_retireCount = 32'hFFFF_FFFF;
    #1;
    release dut.r_retireCount;
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("wrap_retire", N*W'(bus.retire_valid), N*W'(1'b1));
    checkOutput("wrap_rcount", N*W'(bus.retire_count), '0);

    // Reset during freeze and flush clears everything; next edge is a normal advance.
    applyStimulus(1'b1, 1'b1, PF, 1'b1, 1'b1, 3'd2, 1'b1);
    checkState("rstfrz", '0, 4'b0000, 1'b0);
    checkOutput("rstfrz_rcount", N*W'(bus.retire_count), '0);
    checkOutput("rstfrz_scount", N*W'(bus.stall_count), '0);
    applyStimulus(1'b0, 1'b1, P1, 1'b0, 1'b0, 3'd0, 1'b0);
    checkState("postrst", P1, 4'b0001, 1'b0);
    checkOutput("postrst_scount", N*W'(bus.stall_count), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
